// File: rtl/cache_arbiter.sv
// Round-robin Wishbone arbiter: I-cache and D-cache line requests onto one memory port,
// with a saturating wait counter that answers RTY to the requester when memory hangs.
module cache_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         icacheCyc_i,
  input  logic         icacheStb_i,
  input  logic         icacheWe_i,
  input  logic [11:0]  icacheAdr_i,
  input  logic [15:0]  icacheSel_i,
  input  logic [127:0] icacheDat_i,
  output logic [127:0] icacheDat_o,
  output logic         icacheAck_o,
  output logic         icacheRty_o,
  input  logic         dcacheCyc_i,
  input  logic         dcacheStb_i,
  input  logic         dcacheWe_i,
  input  logic [11:0]  dcacheAdr_i,
  input  logic [15:0]  dcacheSel_i,
  input  logic [127:0] dcacheDat_i,
  output logic [127:0] dcacheDat_o,
  output logic         dcacheAck_o,
  output logic         dcacheRty_o,
  output logic         memCyc_o,
  output logic         memStb_o,
  output logic         memWe_o,
  output logic [11:0]  memAdr_o,
  output logic [15:0]  memSel_o,
  output logic [127:0] memDat_o,
  input  logic [127:0] memDat_i,
  input  logic         memAck_i,
  input  logic         memRty_i
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

  localparam int          CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TLAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TLAST   = TLAST_INT[CW-1:0];
  localparam logic        TO_EN     = (TIMEOUT_CYCLES != 0);

  state_e        state_q;
  logic          lastD_q;
  logic [CW-1:0] waitCnt_q;

  logic          reqI, reqD, serveI, serveD, serving;
  logic          gCyc, gStb, gWe;
  logic [11:0]   gAdr;
  logic [15:0]   gSel;
  logic [127:0]  gDat;
  logic          memDone, timeoutHit, otherReq;

  assign reqI    = icacheCyc_i & icacheStb_i;
  assign reqD    = dcacheCyc_i & dcacheStb_i;
  assign serveI  = (state_q == SERVE_I);
  assign serveD  = (state_q == SERVE_D);
  assign serving = serveI | serveD;
  assign memDone = memAck_i | memRty_i;
  assign otherReq = serveI ? reqD : reqI;

  always_comb begin
    gCyc = 1'b0;
    gStb = 1'b0;
    gWe  = 1'b0;
    gAdr = '0;
    gSel = '0;
    gDat = '0;
    if (serveI) begin
      gCyc = icacheCyc_i;
      gStb = icacheStb_i;
      gWe  = icacheWe_i;
      gAdr = icacheAdr_i;
      gSel = icacheSel_i;
      gDat = icacheDat_i;
    end else if (serveD) begin
      gCyc = dcacheCyc_i;
      gStb = dcacheStb_i;
      gWe  = dcacheWe_i;
      gAdr = dcacheAdr_i;
      gSel = dcacheSel_i;
      gDat = dcacheDat_i;
    end
  end

  // A real memory response in the deadline cycle beats the timeout.
  assign timeoutHit = TO_EN & serving & gCyc & ~memDone & (waitCnt_q == TLAST);

  assign memCyc_o = gCyc & ~timeoutHit;
  assign memStb_o = gStb & ~timeoutHit;
  assign memWe_o  = gWe;
  assign memAdr_o = gAdr;
  assign memSel_o = gSel;
  assign memDat_o = gDat;

  assign icacheDat_o = memDat_i;
  assign dcacheDat_o = memDat_i;
  assign icacheAck_o = serveI & memAck_i;
  assign dcacheAck_o = serveD & memAck_i;
  assign icacheRty_o = serveI & (memRty_i | timeoutHit);
  assign dcacheRty_o = serveD & (memRty_i | timeoutHit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lastD_q   <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          waitCnt_q <= '0;
          if (reqI && reqD) state_q <= lastD_q ? SERVE_I : SERVE_D;
          else if (reqI)    state_q <= SERVE_I;
          else if (reqD)    state_q <= SERVE_D;
        end
        SERVE_I, SERVE_D: begin
          if (!gCyc) begin
            state_q <= IDLE;
          end else if (memDone || timeoutHit) begin
            lastD_q   <= serveD;
            waitCnt_q <= '0;
            if (otherReq) state_q <= serveI ? SERVE_D : SERVE_I;
            else          state_q <= IDLE;
          end else if (waitCnt_q != '1) begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: stimulus pushes expected slave responses into a queue,
// a negedge monitor pops and compares them whenever a slave sees ACK or RTY.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         icacheCyc_i, icacheStb_i, icacheWe_i;
  logic [11:0]  icacheAdr_i;
  logic [15:0]  icacheSel_i;
  logic [127:0] icacheDat_i, icacheDat_o;
  logic         icacheAck_o, icacheRty_o;
  logic         dcacheCyc_i, dcacheStb_i, dcacheWe_i;
  logic [11:0]  dcacheAdr_i;
  logic [15:0]  dcacheSel_i;
  logic [127:0] dcacheDat_i, dcacheDat_o;
  logic         dcacheAck_o, dcacheRty_o;
  logic         memCyc_o, memStb_o, memWe_o;
  logic [11:0]  memAdr_o;
  logic [15:0]  memSel_o;
  logic [127:0] memDat_o, memDat_i;
  logic         memAck_i, memRty_i;

  typedef struct {
    bit           isD;
    bit           ack;
    bit           rty;
    bit           cyc;
    logic [11:0]  adr;
    logic [127:0] data;
  } exp_t;

  exp_t expQ[$];
  int   respCyc[$];
  int   total = 0;
  int   bad = 0;
  int   cycCnt = 0;
  int   memLatency = 0;
  int   stbCnt = 0;
  bit   counting = 1'b0;
  int   iRem = 0, dRem = 0;
  bit   iSeen = 1'b0, dSeen = 1'b0;

  cache_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .icacheCyc_i(icacheCyc_i), .icacheStb_i(icacheStb_i), .icacheWe_i(icacheWe_i),
    .icacheAdr_i(icacheAdr_i), .icacheSel_i(icacheSel_i), .icacheDat_i(icacheDat_i),
    .icacheDat_o(icacheDat_o), .icacheAck_o(icacheAck_o), .icacheRty_o(icacheRty_o),
    .dcacheCyc_i(dcacheCyc_i), .dcacheStb_i(dcacheStb_i), .dcacheWe_i(dcacheWe_i),
    .dcacheAdr_i(dcacheAdr_i), .dcacheSel_i(dcacheSel_i), .dcacheDat_i(dcacheDat_i),
    .dcacheDat_o(dcacheDat_o), .dcacheAck_o(dcacheAck_o), .dcacheRty_o(dcacheRty_o),
    .memCyc_o(memCyc_o), .memStb_o(memStb_o), .memWe_o(memWe_o), .memAdr_o(memAdr_o),
    .memSel_o(memSel_o), .memDat_o(memDat_o), .memDat_i(memDat_i),
    .memAck_i(memAck_i), .memRty_i(memRty_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCnt++;

  function automatic logic [127:0] respData(input logic [11:0] adr);
    return {16'hDEAD, 4'h0, adr, 80'h0, 16'hBEEF};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit isD, input logic [11:0] adr, input bit we,
                               input logic [15:0] sel, input logic [127:0] dat, input int n);
    if (isD) begin
      dcacheCyc_i = 1'b1; dcacheStb_i = 1'b1; dcacheWe_i = we;
      dcacheAdr_i = adr;  dcacheSel_i = sel;  dcacheDat_i = dat; dRem = n;
    end else begin
      icacheCyc_i = 1'b1; icacheStb_i = 1'b1; icacheWe_i = we;
      icacheAdr_i = adr;  icacheSel_i = sel;  icacheDat_i = dat; iRem = n;
    end
  endtask

  task automatic pushExp(input bit isD, input bit ack, input bit rty, input bit cyc, input logic [11:0] adr);
    exp_t e;
    e.isD = isD; e.ack = ack; e.rty = rty; e.cyc = cyc; e.adr = adr; e.data = respData(adr);
    expQ.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    int k = 0;
    while (expQ.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drain pending responses", expQ.size(), 0);
    @(negedge clk);
  endtask

  // Memory model: ACK in the Nth cycle after STB is first seen; latency 0 never answers.
  always @(posedge clk) begin
    #1;
    memAck_i = 1'b0;
    memRty_i = 1'b0;
    if (memLatency != 0 && (memStb_o || counting)) begin
      counting = 1'b1;
      stbCnt++;
      if (stbCnt == memLatency) begin
        memAck_i = 1'b1;
        memDat_i = respData(memAdr_o);
        stbCnt   = 0;
        counting = 1'b0;
      end
    end else begin
      counting = 1'b0;
      stbCnt   = 0;
    end
  end

  // L1 models: hold the request for n responses, then drop it after the completing edge.
  always @(negedge clk) begin
    if (icacheAck_o || icacheRty_o) iSeen = 1'b1;
    if (dcacheAck_o || dcacheRty_o) dSeen = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (iSeen) begin
      iSeen = 1'b0;
      iRem--;
      if (iRem <= 0) begin icacheCyc_i = 1'b0; icacheStb_i = 1'b0; end
    end
    if (dSeen) begin
      dSeen = 1'b0;
      dRem--;
      if (dRem <= 0) begin dcacheCyc_i = 1'b0; dcacheStb_i = 1'b0; end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (icacheAck_o || icacheRty_o || dcacheAck_o || dcacheRty_o)) begin
      respCyc.push_back(cycCnt);
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected response: got iAck=%b iRty=%b dAck=%b dRty=%b expected none",
                 icacheAck_o, icacheRty_o, dcacheAck_o, dcacheRty_o);
      end else begin
        e = expQ.pop_front();
        checkOutput("resp port", dcacheAck_o | dcacheRty_o, e.isD);
        checkOutput("resp ack", e.isD ? dcacheAck_o : icacheAck_o, e.ack);
        checkOutput("resp rty", e.isD ? dcacheRty_o : icacheRty_o, e.rty);
        checkOutput("other port quiet", e.isD ? (icacheAck_o | icacheRty_o) : (dcacheAck_o | dcacheRty_o), 0);
        checkOutput("mem adr at resp", memAdr_o, e.adr);
        checkOutput("mem cyc at resp", memCyc_o, e.cyc);
        if (e.ack) checkOutput("resp data", e.isD ? dcacheDat_o : icacheDat_o, e.data);
      end
    end
  end

  initial begin
    int k;
    rst_n = 1'b0;
    icacheCyc_i = 0; icacheStb_i = 0; icacheWe_i = 0; icacheAdr_i = '0; icacheSel_i = '0; icacheDat_i = '0;
    dcacheCyc_i = 0; dcacheStb_i = 0; dcacheWe_i = 0; dcacheAdr_i = '0; dcacheSel_i = '0; dcacheDat_i = '0;
    memAck_i = 0; memRty_i = 0;
    memDat_i = 128'h5A5A_0000_1111_2222_3333_4444_5555_A5A5;
    icacheCyc_i = 1'b1; icacheStb_i = 1'b1; icacheAdr_i = 12'hFFF;
    #3;
    checkOutput("reset mem cyc", memCyc_o, 0);
    checkOutput("reset mem stb", memStb_o, 0);
    checkOutput("reset mem we", memWe_o, 0);
    checkOutput("reset mem adr", memAdr_o, 0);
    checkOutput("reset mem sel", memSel_o, 0);
    checkOutput("reset mem dat", memDat_o, 0);
    checkOutput("reset i ack/rty", {icacheAck_o, icacheRty_o}, 0);
    checkOutput("reset d ack/rty", {dcacheAck_o, dcacheRty_o}, 0);
    checkOutput("reset i dat mirror", icacheDat_o, 128'h5A5A_0000_1111_2222_3333_4444_5555_A5A5);
    checkOutput("reset d dat mirror", dcacheDat_o, 128'h5A5A_0000_1111_2222_3333_4444_5555_A5A5);
    icacheCyc_i = 1'b0; icacheStb_i = 1'b0; icacheAdr_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous first requests: D wins, I follows with no bubble.
    memLatency = 2;
    respCyc.delete();
    k = cycCnt;
    applyStimulus(0, 12'h0AA, 0, 16'hFFFF, '0, 1);
    applyStimulus(1, 12'h0BB, 0, 16'hFFFF, '0, 1);
    pushExp(1, 1, 0, 1, 12'h0BB);
    pushExp(0, 1, 0, 1, 12'h0AA);
    waitDrain(40);
    checkOutput("tie resp count", respCyc.size(), 2);
    if (respCyc.size() >= 2) begin
      checkOutput("tie D ack cycle", respCyc[0], k + 2);
      checkOutput("tie I ack cycle", respCyc[1], k + 4);
    end

    // Single I-fill, ACK in the third grant cycle.
    memLatency = 3;
    respCyc.delete();
    k = cycCnt;
    applyStimulus(0, 12'h123, 0, 16'hFFFF, '0, 1);
    pushExp(0, 1, 0, 1, 12'h123);
    waitDrain(40);
    @(negedge clk);
    checkOutput("ifill back to idle", memCyc_o, 0);
    if (respCyc.size() >= 1) checkOutput("ifill ack cycle", respCyc[0], k + 3);

    // Fairness: both continuous, memory answers in the first grant cycle.
    memLatency = 1;
    respCyc.delete();
    k = cycCnt;
    applyStimulus(0, 12'h111, 0, 16'hFFFF, '0, 4);
    applyStimulus(1, 12'h222, 0, 16'hFFFF, '0, 4);
    for (int i = 0; i < 4; i++) begin
      pushExp(1, 1, 0, 1, 12'h222);
      pushExp(0, 1, 0, 1, 12'h111);
    end
    waitDrain(60);
    checkOutput("fair resp count", respCyc.size(), 8);
    if (respCyc.size() >= 8) begin
      checkOutput("fair first ack", respCyc[0], k + 1);
      checkOutput("fair no bubbles", respCyc[7], k + 8);
    end

    // Write-back pass-through.
    memLatency = 3;
    applyStimulus(1, 12'h0FF, 1, 16'hFFFF, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1);
    pushExp(1, 1, 0, 1, 12'h0FF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("wb cyc", memCyc_o, 1);
      checkOutput("wb we", memWe_o, 1);
      checkOutput("wb sel", memSel_o, 16'hFFFF);
      checkOutput("wb adr", memAdr_o, 12'h0FF);
      checkOutput("wb dat", memDat_o, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
    end
    waitDrain(40);

    // Timeout with a silent memory: RTY in the 4th grant cycle, CYC forced low.
    memLatency = 0;
    respCyc.delete();
    k = cycCnt;
    applyStimulus(0, 12'h044, 0, 16'hFFFF, '0, 1);
    pushExp(0, 0, 1, 0, 12'h044);
    waitDrain(40);
    if (respCyc.size() >= 1) checkOutput("timeout rty cycle", respCyc[0], k + 4);

    // Memory ACK in the deadline cycle: ACK only.
    memLatency = 4;
    respCyc.delete();
    k = cycCnt;
    applyStimulus(1, 12'h0DD, 0, 16'hFFFF, '0, 1);
    pushExp(1, 1, 0, 1, 12'h0DD);
    waitDrain(40);
    if (respCyc.size() >= 1) checkOutput("deadline ack cycle", respCyc[0], k + 4);

    // Abort mid-wait, then a tie proves last-served stayed D.
    memLatency = 0;
    applyStimulus(0, 12'h055, 0, 16'hFFFF, '0, 1);
    repeat (2) @(negedge clk);
    icacheCyc_i = 1'b0; icacheStb_i = 1'b0; iRem = 0;
    #1;
    checkOutput("abort cyc follows port", memCyc_o, 0);
    @(negedge clk);
    memLatency = 1;
    applyStimulus(0, 12'h056, 0, 16'hFFFF, '0, 1);
    applyStimulus(1, 12'h0D6, 0, 16'hFFFF, '0, 1);
    pushExp(0, 1, 0, 1, 12'h056);
    pushExp(1, 1, 0, 1, 12'h0D6);
    #1;
    checkOutput("abort went idle", memCyc_o, 0);
    waitDrain(40);

    // Reset mid-transaction, then a tie proves last-served reset to I.
    memLatency = 0;
    applyStimulus(1, 12'h0E8, 0, 16'hFFFF, '0, 1);
    repeat (2) @(negedge clk);
    checkOutput("pre-reset granted", memCyc_o, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset cyc", memCyc_o, 0);
    checkOutput("async reset stb", memStb_o, 0);
    checkOutput("async reset acks", {icacheAck_o, icacheRty_o, dcacheAck_o, dcacheRty_o}, 0);
    dcacheCyc_i = 1'b0; dcacheStb_i = 1'b0; dRem = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    memLatency = 1;
    applyStimulus(0, 12'h0E1, 0, 16'hFFFF, '0, 1);
    applyStimulus(1, 12'h0E2, 0, 16'hFFFF, '0, 1);
    pushExp(1, 1, 0, 1, 12'h0E2);
    pushExp(0, 1, 0, 1, 12'h0E1);
    waitDrain(40);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
